// File: rtl/puc_pkg.sv
// Shared definitions for the instruction packer: widths, field layout,
// operand-type encodings and the loader state enum.
package puc_pkg;

    localparam int INSTRUCTION_WIDTH = 40;
    localparam int OPCODE_WIDTH      = 6;
    localparam int FIELD_ADDR_WIDTH  = 8;

    // High fields are placed relative to the word MSB (bit W-n)
    localparam int RHA2_FROM_TOP = 1;
    localparam int RHA1_FROM_TOP = 2;
    localparam int OP_FROM_TOP   = 3;
    localparam int A1_FROM_TOP   = 9;
    localparam int A2_FROM_TOP   = 17;
    localparam int AO_FROM_TOP   = 25;

    localparam int RHA0_BIT = 6;
    localparam int A1T_LO   = 4;
    localparam int A2T_LO   = 2;
    localparam int OT_LO    = 0;

    localparam logic [FIELD_ADDR_WIDTH-1:0] REG_ADDR_MAX = 8'd7;

    typedef enum logic [1:0] {
        OT_IMM = 2'b00,
        OT_REG = 2'b01,
        OT_MEM = 2'b10,
        OT_IND = 2'b11
    } operand_type_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_DRAIN = 2'b10
    } state_e;

endpackage

// File: rtl/instruction_encoder.sv
// Combinational packing of one field tuple into an instruction word.
// Bits not covered by a field are driven 0.
module instruction_encoder #(
    parameter int INSTRUCTION_WIDTH = puc_pkg::INSTRUCTION_WIDTH,
    parameter int OPCODE_WIDTH      = puc_pkg::OPCODE_WIDTH
) (
    input  logic [OPCODE_WIDTH-1:0]      opCode,
    input  logic [7:0]                   address1In,
    input  logic [7:0]                   address2In,
    input  logic [7:0]                   addressOut,
    input  logic [1:0]                   address1Type,
    input  logic [1:0]                   address2Type,
    input  logic [1:0]                   outType,
    input  logic [2:0]                   registerHasAddress,
    output logic [INSTRUCTION_WIDTH-1:0] word
);
    import puc_pkg::*;

    localparam int W = INSTRUCTION_WIDTH;

    always_comb begin
        word = '0;
        word[W-RHA2_FROM_TOP] = registerHasAddress[2];
        word[W-RHA1_FROM_TOP] = registerHasAddress[1];
        word[W-OP_FROM_TOP -: OPCODE_WIDTH] = opCode;
        word[W-A1_FROM_TOP -: 8] = address1In;
        word[W-A2_FROM_TOP -: 8] = address2In;
        word[W-AO_FROM_TOP -: 8] = addressOut;
        word[RHA0_BIT]    = registerHasAddress[0];
        word[A1T_LO +: 2] = address1Type;
        word[A2T_LO +: 2] = address2Type;
        word[OT_LO +: 2]  = outType;
    end

endmodule

// File: rtl/instruction_packer.sv
// Loads programLength packed instruction words into program memory from 0.
// Optional operand range check enabled by defining PACKER_FIELD_CHECK_EN.
module instruction_packer #(
    parameter int INSTRUCTION_WIDTH = puc_pkg::INSTRUCTION_WIDTH,
    parameter int OPCODE_WIDTH      = puc_pkg::OPCODE_WIDTH,
    parameter int ADDR_WIDTH        = 8
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          programLength,
    input  logic                         fieldValid,
    output logic                         fieldReady,
    input  logic [OPCODE_WIDTH-1:0]      opCode,
    input  logic [7:0]                   address1In,
    input  logic [7:0]                   address2In,
    input  logic [7:0]                   addressOut,
    input  logic [1:0]                   address1Type,
    input  logic [1:0]                   address2Type,
    input  logic [1:0]                   outType,
    input  logic [2:0]                   registerHasAddress,
    output logic                         memWrite,
    input  logic                         memReady,
    output logic [ADDR_WIDTH-1:0]        memAddress,
    output logic [INSTRUCTION_WIDTH-1:0] memData,
    output logic                         busy,
    output logic                         done,
    output logic                         fieldError
);
    import puc_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_e                         state;
    logic [ADDR_WIDTH:0]            prog_len;
    logic [ADDR_WIDTH:0]            word_count;
    logic [INSTRUCTION_WIDTH-1:0]   word;
    logic                           accept;
    logic                           wr_done;
    logic                           zero_done;

    instruction_encoder #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .OPCODE_WIDTH      (OPCODE_WIDTH)
    ) u_encoder (
        .opCode             (opCode),
        .address1In         (address1In),
        .address2In         (address2In),
        .addressOut         (addressOut),
        .address1Type       (address1Type),
        .address2Type       (address2Type),
        .outType            (outType),
        .registerHasAddress (registerHasAddress),
        .word               (word)
    );

    // A new tuple may enter whenever the output register is empty or draining
    assign fieldReady = (state == S_LOAD) && (!memWrite || memReady);
    assign accept     = fieldReady && fieldValid;
    assign wr_done    = memWrite && memReady;
    assign busy       = (state != S_IDLE);
    assign done       = zero_done || ((state == S_DRAIN) && wr_done);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= S_IDLE;
            prog_len   <= '0;
            word_count <= '0;
            memWrite   <= 1'b0;
            memData    <= '0;
            memAddress <= '0;
            zero_done  <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            if (wr_done) begin
                memAddress <= memAddress + ADDR_ONE;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        prog_len   <= programLength;
                        word_count <= '0;
                        memAddress <= '0;
                        if (programLength == '0) begin
                            zero_done <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        memData    <= word;
                        memWrite   <= 1'b1;
                        word_count <= word_count + CNT_ONE;
                        if (word_count + CNT_ONE == prog_len) begin
                            state <= S_DRAIN;
                        end
                    end else if (memReady) begin
                        memWrite <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (wr_done) begin
                        memWrite <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PACKER_FIELD_CHECK_EN
    logic bad_field;

    always_comb begin
        bad_field = ((address1Type == OT_REG) && (address1In > REG_ADDR_MAX))
                 || ((address2Type == OT_REG) && (address2In > REG_ADDR_MAX))
                 || ((outType == OT_REG) && (addressOut > REG_ADDR_MAX));
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fieldError <= 1'b0;
        end else if (accept && bad_field) begin
            fieldError <= 1'b1;
        end
    end
`else
    assign fieldError = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_packer.sv
// Directed bench for instruction_packer with a write scoreboard.
// Expected words come from an independent packing model.
module tb_instruction_packer;

    typedef struct packed {
        logic [7:0]  a;
        logic [39:0] d;
    } exp_t;

    logic        clock;
    logic        resetN;
    logic        start;
    logic [8:0]  programLength;
    logic        fieldValid;
    logic        fieldReady;
    logic [5:0]  opCode;
    logic [7:0]  address1In;
    logic [7:0]  address2In;
    logic [7:0]  addressOut;
    logic [1:0]  address1Type;
    logic [1:0]  address2Type;
    logic [1:0]  outType;
    logic [2:0]  registerHasAddress;
    logic        memWrite;
    logic        memReady;
    logic [7:0]  memAddress;
    logic [39:0] memData;
    logic        busy;
    logic        done;
    logic        fieldError;

    int          total = 0;
    int          bad = 0;
    int          writes = 0;
    int          dones = 0;
    int          cyc = 0;
    bit          fixed = 0;
    logic [7:0]  exp_addr = '0;
    exp_t        exp_q[$];
    int          wr_cycles[$];
    logic        done_wr;
    logic [7:0]  done_addr;
    logic [39:0] last_data;
    logic        hold_prev = 0;
    logic [39:0] hold_d;
    logic [7:0]  hold_a;

    instruction_packer dut (
        .clock              (clock),
        .resetN             (resetN),
        .start              (start),
        .programLength      (programLength),
        .fieldValid         (fieldValid),
        .fieldReady         (fieldReady),
        .opCode             (opCode),
        .address1In         (address1In),
        .address2In         (address2In),
        .addressOut         (addressOut),
        .address1Type       (address1Type),
        .address2Type       (address2Type),
        .outType            (outType),
        .registerHasAddress (registerHasAddress),
        .memWrite           (memWrite),
        .memReady           (memReady),
        .memAddress         (memAddress),
        .memData            (memData),
        .busy               (busy),
        .done               (done),
        .fieldError         (fieldError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [39:0] pack(
        input logic [5:0] op, input logic [7:0] a1, input logic [7:0] a2,
        input logic [7:0] ao, input logic [1:0] t1, input logic [1:0] t2,
        input logic [1:0] to, input logic [2:0] r);
        logic [39:0] w;
        w = '0;
        w[39] = r[2];
        w[38] = r[1];
        w[37:32] = op;
        w[31:24] = a1;
        w[23:16] = a2;
        w[15:8] = ao;
        w[6] = r[0];
        w[5:4] = t1;
        w[3:2] = t2;
        w[1:0] = to;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic new_tuple();
        opCode = 6'($urandom_range(0, 63));
        address1Type = 2'($urandom_range(0, 3));
        address2Type = 2'($urandom_range(0, 3));
        outType = 2'($urandom_range(0, 3));
        address1In = 8'($urandom_range(0, 255));
        address2In = 8'($urandom_range(0, 255));
        addressOut = 8'($urandom_range(0, 255));
        registerHasAddress = 3'($urandom_range(0, 7));
        if (address1Type == 2'b01) address1In[7:3] = '0;
        if (address2Type == 2'b01) address2In[7:3] = '0;
        if (outType == 2'b01) addressOut[7:3] = '0;
    endtask

    // Scoreboard: pop on completed write, push on accepted tuple
    always @(negedge clock) begin
        if (!resetN) begin
            hold_prev = 0;
        end else begin
            if (hold_prev && memWrite) begin
                chk("hold_data", memData, hold_d);
                chk("hold_addr", memAddress, hold_a);
            end
            if (memWrite && memReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", memAddress, e.a);
                    chk("wr_data", memData, e.d);
                end
                writes++;
                wr_cycles.push_back(cyc);
                last_data = memData;
            end
            if (done) begin
                dones++;
                done_wr = memWrite && memReady;
                done_addr = memAddress;
            end
            hold_prev = memWrite && !memReady;
            hold_d = memData;
            hold_a = memAddress;
            if (fieldValid && fieldReady) begin
                exp_q.push_back('{exp_addr, pack(opCode, address1In, address2In,
                    addressOut, address1Type, address2Type, outType,
                    registerHasAddress)});
                exp_addr++;
            end
        end
    end

    task automatic wait_done(input int budget, input int stall_at,
                             input int stall_n);
        int d0 = dones;
        int w0 = writes;
        int n = 0;
        int st = 0;
        while (dones == d0 && n < budget) begin
            tick();
            n++;
            if (!fixed) new_tuple();
            if (stall_at >= 0 && writes - w0 >= stall_at && st < stall_n) begin
                memReady = 1'b0;
                st++;
                #1;
                chk("stall_ready_low", fieldReady, 0);
            end else begin
                memReady = 1'b1;
            end
        end
        chk("done_seen", dones != d0, 1);
    endtask

    task automatic run(input int len, input int budget, input int stall_at,
                       input int stall_n);
        exp_addr = '0;
        start = 1'b1;
        programLength = 9'(len);
        tick();
        start = 1'b0;
        wait_done(budget, stall_at, stall_n);
    endtask

    initial begin
        int w0;
        int d0;
        resetN = 1'b0;
        start = 1'b0;
        programLength = '0;
        fieldValid = 1'b0;
        memReady = 1'b1;
        new_tuple();
        tick();
        tick();
        chk("rst_memWrite", memWrite, 0);
        chk("rst_memData", memData, 0);
        chk("rst_memAddress", memAddress, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fieldReady", fieldReady, 0);
        chk("rst_fieldError", fieldError, 0);
        resetN = 1'b1;
        tick();

        // Round trip of a known tuple
        fixed = 1;
        opCode = 6'h15;
        address1In = 8'h12;
        address2In = 8'h34;
        addressOut = 8'h56;
        address1Type = 2'd1;
        address2Type = 2'd2;
        outType = 2'd3;
        registerHasAddress = 3'b101;
        fieldValid = 1'b1;
        w0 = writes;
        run(1, 20, -1, 0);
        chk("roundtrip_word", last_data, 40'h95_1234_565B);
        chk("roundtrip_writes", writes - w0, 1);
        fixed = 0;

        // Full-rate load of 4 words
        wr_cycles.delete();
        w0 = writes;
        run(4, 30, -1, 0);
        chk("full_writes", writes - w0, 4);
        chk("full_consecutive", wr_cycles[$] - wr_cycles[0], 3);
        chk("done_with_write", done_wr, 1);
        chk("done_addr", done_addr, 3);
        chk("busy_after_done", busy, 0);

        // Backpressure mid-load
        w0 = writes;
        run(6, 40, 2, 3);
        chk("stall_writes", writes - w0, 6);
        chk("stall_queue_empty", exp_q.size(), 0);

        // Zero-length load
        w0 = writes;
        d0 = dones;
        run(0, 10, -1, 0);
        chk("zero_busy", busy, 0);
        tick();
        tick();
        tick();
        chk("zero_done_once", dones - d0, 1);
        chk("zero_no_write", writes - w0, 0);
        chk("zero_memWrite", memWrite, 0);

        // Start while busy is ignored
        fieldValid = 1'b0;
        exp_addr = '0;
        w0 = writes;
        start = 1'b1;
        programLength = 9'd3;
        tick();
        start = 1'b0;
        tick();
        chk("busy_in_load", busy, 1);
        start = 1'b1;
        programLength = 9'd7;
        tick();
        start = 1'b0;
        fieldValid = 1'b1;
        wait_done(50, -1, 0);
        chk("ignored_start_writes", writes - w0, 3);

        // Address wrap past 2^ADDR_WIDTH
        w0 = writes;
        run(260, 400, -1, 0);
        chk("wrap_writes", writes - w0, 260);
        chk("wrap_last_addr", memAddress, 8'd4);

        // Reset mid-load with a pending write
        exp_addr = '0;
        w0 = writes;
        start = 1'b1;
        programLength = 9'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && writes - w0 < 2; i++) begin
            tick();
            new_tuple();
        end
        chk("pre_reset_writes", writes - w0, 2);
        memReady = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        chk("mid_rst_memWrite", memWrite, 0);
        chk("mid_rst_memData", memData, 0);
        chk("mid_rst_memAddress", memAddress, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fieldReady", fieldReady, 0);
        chk("mid_rst_fieldError", fieldError, 0);
        exp_q.delete();
        tick();
        resetN = 1'b1;
        memReady = 1'b1;
        w0 = writes;
        run(2, 20, -1, 0);
        chk("post_reset_writes", writes - w0, 2);
        chk("post_reset_last_addr", done_addr, 1);

        // Operand range check
        fixed = 1;
        opCode = 6'h01;
        address1Type = 2'b01;
        address1In = 8'h09;
        address2Type = 2'b00;
        address2In = 8'h20;
        outType = 2'b10;
        addressOut = 8'h30;
        registerHasAddress = 3'b000;
        run(1, 20, -1, 0);
        fieldValid = 1'b0;
`ifdef PACKER_FIELD_CHECK_EN
        chk("field_error_set", fieldError, 1);
        tick();
        tick();
        tick();
        chk("field_error_held", fieldError, 1);
`else
        chk("field_error_tied", fieldError, 0);
        tick();
        tick();
        tick();
        chk("field_error_still_0", fieldError, 0);
`endif
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
